// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and memory-interface state encoding
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} mem_state_t;
endpackage

// File: rtl/reg32.sv
// reg32: generic enabled register with asynchronous active-low clear
// clock/clear_n: clock and async clear; i_en: load enable; i_d: data in; o_q: stored value
module reg32 #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) o_q <= '0;
    else if (i_en) o_q <= i_d;
endmodule

// File: rtl/mem_interface.sv
// mem_interface: MAR/MDR stage with req/ack memory handshake, timeout and done pulse
// BusMuxOut/MARin/MDRin: bus loads in IDLE; Read/Write: start a transaction
// mem_*: single-port memory handshake; mdr_out: MDR to bus mux; busy/done/error: sequencer status
module mem_interface #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import cpu_pkg::*;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  mem_state_t        r_state, w_next;
  logic [7:0]        r_cnt, w_cnt;
  logic              r_rd, r_wr, r_done, r_error, w_error;
  logic              w_idle, w_mdr_en;
  logic [DATA_W-1:0] w_mdr_d;
  assign w_idle   = r_state == IDLE;
  // MDR takes the bus only while idle, and memory data only on a read ack
  assign w_mdr_en = (w_idle && MDRin) || (r_state == READ && mem_ack);
  assign w_mdr_d  = w_idle ? BusMuxOut : mem_rdata;
  reg32 #(.W(ADDR_W)) u_mar (
    .clock   (clock),
    .clear_n (clear_n),
    .i_en    (w_idle && MARin),
    .i_d     (BusMuxOut[ADDR_W-1:0]),
    .o_q     (mem_addr)
  );
  reg32 #(.W(DATA_W)) u_mdr (
    .clock   (clock),
    .clear_n (clear_n),
    .i_en    (w_mdr_en),
    .i_d     (w_mdr_d),
    .o_q     (mdr_out)
  );
  assign mem_wdata = mdr_out;
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt + 8'd1;
    w_error = r_error;
    if (w_idle) begin
      w_cnt = '0;
      if (Read && Write) w_error = 1'b1;
      else if (Read || Write) begin
        w_next  = Read ? READ : WRITE;
        w_error = 1'b0;
      end
    end else if (mem_ack) w_next = IDLE;
    else if (r_cnt == LAST) begin
      w_next  = IDLE;
      w_error = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_rd    <= w_next == READ;
      r_wr    <= w_next == WRITE;
      r_done  <= !w_idle && mem_ack;
      r_error <= w_error;
    end
  assign mem_rd = r_rd;
  assign mem_wr = r_wr;
  assign busy   = r_state != IDLE;
  assign done   = r_done;
  assign error  = r_error;
endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: directed and randomized checks of mem_interface against a transaction-level model
module tb_mem_interface;
  localparam int TO = 4;
  logic        clock = 1'b0, clear_n = 1'b0;
  logic [31:0] BusMuxOut = '0, mem_rdata = '0;
  logic        MARin = 0, MDRin = 0, Read = 0, Write = 0, mem_ack = 0;
  logic [31:0] mdr_out, mem_wdata;
  logic [8:0]  mem_addr;
  logic        mem_rd, mem_wr, busy, done, error;
  int total = 0, bad = 0;
  mem_interface #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(TO)) dut (
    .clock(clock), .clear_n(clear_n), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .mdr_out(mdr_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .error(error)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #2;
  endtask
  // model: m_kind 0=no request, 1=read pending, 2=write pending; m_held = cycles the request has been up
  logic [8:0]  m_mar;
  logic [31:0] m_mdr;
  int          m_kind, m_held;
  logic        m_done, m_err;
  always @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      m_mar <= '0; m_mdr <= '0; m_kind <= 0; m_held <= 0; m_done <= 0; m_err <= 0;
    end else begin
      m_done <= 0;
      if (m_kind == 0) begin
        if (MARin) m_mar <= BusMuxOut[8:0];
        if (MDRin) m_mdr <= BusMuxOut;
        if (Read && Write) m_err <= 1;
        else if (Read || Write) begin
          m_kind <= Read ? 1 : 2;
          m_held <= 1;
          m_err  <= 0;
        end
      end else if (mem_ack) begin
        if (m_kind == 1) m_mdr <= mem_rdata;
        m_kind <= 0;
        m_done <= 1;
      end else if (m_held == TO) begin
        m_kind <= 0;
        m_err  <= 1;
      end else m_held <= m_held + 1;
    end
  always @(negedge clock) begin
    chk("mdr_out", mdr_out, m_mdr);
    chk("mem_wdata", mem_wdata, m_mdr);
    chk("mem_addr", 32'(mem_addr), 32'(m_mar));
    chk("mem_rd", 32'(mem_rd), 32'(m_kind == 1));
    chk("mem_wr", 32'(mem_wr), 32'(m_kind == 2));
    chk("busy", 32'(busy), 32'(m_kind != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("error", 32'(error), 32'(m_err));
  end
  initial begin
    int n, dn;
    repeat (2) @(posedge clock);
    #2 clear_n = 1;
    chk("rst_mdr", mdr_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    Read = 1; step; Read = 0; step; step;
    chk("midrd_rd", 32'(mem_rd), 32'd1);
    clear_n = 0;
    #1;
    chk("midrd_rd_drop", 32'(mem_rd), 32'd0);
    chk("midrd_busy", 32'(busy), 32'd0);
    chk("midrd_mdr", mdr_out, 32'h0);
    chk("midrd_err", 32'(error), 32'd0);
    step; clear_n = 1; step;
    chk("midrd_idle", 32'(busy), 32'd0);
    BusMuxOut = 32'h41; MARin = 1; step;
    MARin = 0; Read = 1; step;
    Read = 0; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    chk("zw_rd", 32'(mem_rd), 32'd1);
    step; mem_ack = 0;
    chk("zw_done", 32'(done), 32'd1);
    chk("zw_mdr", mdr_out, 32'hDEAD_BEEF);
    chk("zw_addr", 32'(mem_addr), 32'h41);
    chk("zw_rd_off", 32'(mem_rd), 32'd0);
    step;
    chk("zw_done_off", 32'(done), 32'd0);
    BusMuxOut = 32'h1234_5678; MDRin = 1; step;
    MDRin = 0; BusMuxOut = 32'h1FF; MARin = 1; step;
    MARin = 0; Write = 1; step;
    Write = 0; MARin = 1; BusMuxOut = 32'h0;
    chk("wr_wr1", 32'(mem_wr), 32'd1);
    step;
    chk("wr_addr2", 32'(mem_addr), 32'h1FF);
    step; mem_ack = 1;
    chk("wr_wdata3", mem_wdata, 32'h1234_5678);
    chk("wr_addr3", 32'(mem_addr), 32'h1FF);
    step; mem_ack = 0; MARin = 0;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_wr_off", 32'(mem_wr), 32'd0);
    chk("wr_addr_end", 32'(mem_addr), 32'h1FF);
    step;
    chk("wr_done_off", 32'(done), 32'd0);
    Read = 1; step; Read = 0;
    n = 0; dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_rd) n++;
      if (done) dn++;
      step;
    end
    chk("to_rd_cycles", 32'(n), 32'd4);
    chk("to_done_cnt", 32'(dn), 32'd0);
    chk("to_err", 32'(error), 32'd1);
    chk("to_mdr", mdr_out, 32'h1234_5678);
    Read = 1; step; Read = 0;
    chk("to_err_clr", 32'(error), 32'd0);
    mem_ack = 1; mem_rdata = 32'hA5A5_A5A5; step; mem_ack = 0;
    chk("to_rd_after", mdr_out, 32'hA5A5_A5A5);
    Read = 1; Write = 1; step; Read = 0; Write = 0;
    chk("ill_rd", 32'(mem_rd), 32'd0);
    chk("ill_wr", 32'(mem_wr), 32'd0);
    chk("ill_err", 32'(error), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    MARin = 1; BusMuxOut = 32'h123; Read = 1; step;
    MARin = 0; Read = 0;
    chk("ls_addr", 32'(mem_addr), 32'h123);
    chk("ls_rd", 32'(mem_rd), 32'd1);
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D; step;
    mem_rdata = 32'h55; step; mem_ack = 0;
    chk("ls_stray_ack", mdr_out, 32'hCAFE_F00D);
    chk("ls_err", 32'(error), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      if (!clear_n) clear_n = 1;
      else if ($urandom_range(199) == 0) clear_n = 0;
      BusMuxOut = $urandom;
      mem_rdata = $urandom;
      MARin = $urandom_range(4) == 0;
      MDRin = $urandom_range(4) == 0;
      Read = $urandom_range(6) == 0;
      Write = $urandom_range(6) == 0;
      mem_ack = $urandom_range(9) < 3;
      step;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Memory-side datapath stage holding MAR and MDR.
- Consumes BusMuxOut as its bus input.
- Produces mdr_out, which drives the bus multiplexer's BusMuxIn_MDR input.
- Runs a request/acknowledge handshake with single-port word memory for the control-unit Read/Write steps, with a timeout and a completion pulse so the sequencer can stall on busy.

Parameters:
- DATA_W, 32, bus and memory word width.
- ADDR_W, 9, MAR width; MAR takes BusMuxOut[ADDR_W-1:0].
- TIMEOUT, 16, maximum cycles to wait for mem_ack before aborting. Legal range is 1 to 255.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- BusMuxOut  in  DATA_W  shared bus value.
- MARin  in  1  load MAR from the bus.
- MDRin  in  1  load MDR from the bus (CPU write path).
- Read  in  1  start a memory read into MDR.
- Write  in  1  start a memory write of MDR.
- mdr_out  out  DATA_W  MDR contents, to BusMuxIn_MDR.
- mem_addr  out  ADDR_W  equals MAR.
- mem_wdata  out  DATA_W  equals MDR.
- mem_rd  out  1  read request, held until ack or timeout.
- mem_wr  out  1  write request, held until ack or timeout.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1 during a read.
- mem_ack  in  1  memory acknowledge.
- busy  out  1  transaction in progress (state is not IDLE).
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky flag: timeout or illegal request.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - MAR, MDR, timeout counter, done and error all become 0; state becomes IDLE.
  - mem_rd and mem_wr drop in the same instant, including mid-transaction.
  - No partial MDR update survives reset.
- FSM states are IDLE, READ and WRITE. mem_rd is a registered output equal to (state==READ); mem_wr equals (state==WRITE).
- In IDLE:
  - MARin=1 loads MAR at the edge.
  - MDRin=1 loads MDR from BusMuxOut at the edge.
  - MARin and MDRin together load both.
  - Read=1 and Write=0: go to READ, clear error, counter=0.
  - Write=1 and Read=0: go to WRITE, clear error, counter=0.
  - Read=1 and Write=1: stay IDLE, set error, start no transaction.
  - Read or Write in the same cycle as MARin/MDRin: the load happens first, and the transaction uses the newly loaded value.
  - mem_ack in IDLE is ignored.
- In READ or WRITE:
  - MARin, MDRin, Read and Write are all ignored, so mem_addr and mem_wdata stay stable for the whole request.
  - mem_ack=1 in READ: MDR <= mem_rdata, state -> IDLE, done=1 next cycle.
  - mem_ack=1 in WRITE: state -> IDLE, done=1 next cycle; MDR unchanged.
  - No ack: counter increments each cycle.
  - Counter reaches TIMEOUT-1 with no ack: state -> IDLE, error=1, done stays 0, MDR unchanged.
  - An ack in that same final cycle wins over the timeout.
- Latency:
  - Read/Write sampled at edge N gives mem_rd/mem_wr high after edge N.
  - Ack sampled at edge M gives MDR valid, done=1 and mem_rd/mem_wr=0 after edge M.
  - With zero-wait memory (ack in the first request cycle), a transaction takes 2 cycles from Read to done.
- done is high for exactly one cycle and never high together with busy.
- busy is high after edge N through edge M.
- error holds until the next legal Read/Write start, or reset.
- Widths:
  - MAR truncates the bus to ADDR_W bits.
  - mdr_out, mem_wdata and mem_addr are plain register outputs with no combinational path from the inputs.
- The counter is 8 bits and never wraps, because TIMEOUT is at most 255.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum mem_state_t (IDLE=2'd0, READ=2'd1, WRITE=2'd2);
  - DATA_W;
  - the default ADDR_W.
- One natural sub-module: reg32 (the generic enabled, async-clear register already used for R0..R15, HI, LO).
  - Instantiate it for MAR (low ADDR_W bits used) and for MDR.
  - The MDR enable and data-select come from the FSM: bus when MDRin in IDLE, mem_rdata on read ack.

Test Plan:
- Reset mid-read: Read, then clear_n=0 on the 3rd wait cycle -> mem_rd=0 immediately, mdr_out=0, busy=0, error=0; after release, the FSM idles.
- Zero-wait read: bus=0x0000_0041 with MARin, then Read, memory acks the first cycle with 0xDEAD_BEEF -> mem_addr=0x041, mdr_out=0xDEAD_BEEF, done pulses exactly 2 cycles after Read.
- Write with 3-cycle wait: MDRin with bus=0x1234_5678, MARin with 0x0000_01FF, Write, ack on the 3rd mem_wr cycle -> mem_wdata=0x1234_5678 and mem_addr=0x1FF throughout; MARin=1 with bus=0x0 during wait leaves mem_addr=0x1FF; done pulses once.
- Timeout: TIMEOUT=4, Read with no ack -> mem_rd high exactly 4 cycles, then error=1, done=0, MDR unchanged; a following Read clears error.
- Illegal request: Read=1 and Write=1 in IDLE -> no mem_rd/mem_wr, error=1, busy=0.
- Load and start together: MARin=1, bus=0x0000_0123, Read=1 on the same edge -> first mem_rd cycle shows mem_addr=0x123; a stray mem_ack while idle leaves MDR unchanged.
